mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly downstream of the ID-stage address/byte-lane processor.
- Consumes the precomputed address, lane-aligned write data, byte select and bad-address flag.
- Runs one req/ack bus transaction per memory instruction and stalls the pipeline until the transaction completes.
- Aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR) into a 32-bit register writeback value. Big-endian lanes: sel[3] is bits 31:24, at address offset 00.

Parameters:
- ADDR_W, 32, bus address width; o_bus_addr is i_mem_addr[ADDR_W-1:0].
- WORD_ALIGN_BUS, 1, when 1, o_bus_addr[1:0] is forced to 00.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  MEM-stage instruction valid.
- i_flush  in  1  exception/pipeline flush.
- i_instr_op  in  6  opcode, decoded with the OP.v opcode macros.
- i_mem_addr  in  32  effective address.
- i_mem_wdata  in  32  lane-aligned store data.
- i_mem_sel  in  4  byte-lane enables.
- i_bad_addr  in  1  misaligned-address flag.
- i_rt_old  in  32  current rt value, used for the LWL/LWR merge.
- i_llbit_clr  in  1  clears the LL bit (ERET); used only with the optional feature.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  ADDR_W  bus address.
- o_bus_wdata  out  32  bus write data.
- o_bus_sel  out  4  bus byte enables.
- i_bus_ack  in  1  transaction done; i_bus_rdata is valid in the same cycle.
- i_bus_rdata  in  32  read data.
- o_stall  out  1  freeze the upstream pipeline.
- o_load_valid  out  1  one-cycle pulse: o_load_data is the writeback value.
- o_load_data  out  32  aligned/extended load result, or SC result.
- o_exc_adel  out  1  load address error.
- o_exc_ades  out  1  store address error.

Behaviour:
- Reset values:
  - State IDLE.
  - o_bus_req, o_bus_we, o_load_valid, o_exc_adel, o_exc_ades = 0.
  - o_bus_addr, o_bus_wdata, o_load_data = 0; o_bus_sel = 0000.
  - LL bit = 0.
- Reset mid-transaction: o_bus_req drops at that same edge; an i_bus_ack arriving afterwards is ignored.
- Memory op (memop) = LB, LBU, LH, LHU, LW, LWL, LWR, LL, SB, SH, SW, SWL, SWR, SC.
- go = i_valid & memop & ~i_flush.

State IDLE:
- If go & i_bad_addr:
  - Load: o_exc_adel = 1 combinationally. Store: o_exc_ades = 1 combinationally.
  - No bus request; o_stall = 0; stay in IDLE.
- If go & ~i_bad_addr:
  - o_stall = 1 combinationally.
  - Register op, addr, wdata, sel, rt_old and we (= store).
  - Next state BUS.

State BUS:
- o_bus_req = 1; bus outputs held stable; o_stall = 1.
- On i_bus_ack: register the formatted rdata into o_load_data; next state DONE.
- i_flush in BUS does not abort the transaction; a sticky drop flag is set and the result is discarded.

State DONE:
- o_bus_req = 0; o_stall = 0.
- o_load_valid = 1 for loads when not dropped.
- Always returns to IDLE.
- Minimum latency: 3 cycles (IDLE→BUS→DONE) with a same-cycle ack. One bubble cycle between back-to-back memory ops is required.

Load formatting (ofs = addr[1:0]; lane 00 = rdata[31:24]):
- LB/LBU: select the lane byte; sign-extend (LB) or zero-extend (LBU).
- LH/LHU: ofs[1]=0 selects rdata[31:16], otherwise rdata[15:0]; sign-extend or zero-extend.
- LW/LL: rdata unchanged.
- LWL:
  - ofs 00: rdata.
  - ofs 01: {rdata[23:0], rt_old[7:0]}.
  - ofs 10: {rdata[15:0], rt_old[15:0]}.
  - ofs 11: {rdata[7:0], rt_old[23:0]}.
- LWR:
  - ofs 00: {rt_old[31:8], rdata[31:24]}.
  - ofs 01: {rt_old[31:16], rdata[31:16]}.
  - ofs 10: {rt_old[31:24], rdata[31:8]}.
  - ofs 11: rdata.
- Stores: o_load_data is unchanged, except for SC.
- Non-memop: transparent; o_stall = 0; no exceptions.

Optional Feature:
- Macro: LLSC_EN.
- Defined:
  - LL completion sets the LL bit.
  - i_llbit_clr clears the LL bit in any state; a clear coinciding with a set wins.
  - SC with LL bit = 1: normal write; in DONE, o_load_data = 1 and o_load_valid = 1; the LL bit is cleared.
  - SC with LL bit = 0: no bus request; one stall cycle; o_load_data = 0 with o_load_valid = 1 via DONE.
- Undefined:
  - LL behaves as LW.
  - SC behaves as SW and always returns o_load_data = 1.
  - i_llbit_clr is ignored.

Test Plan:
- LB, addr 0x1001, rdata 0x11223344, ack in the first BUS cycle -> o_load_data 0x00000022; o_load_valid pulses 2 cycles after go.
- LB, addr 0x1003, rdata 0xAABBCC80 -> 0xFFFFFF80. LBU at the same address -> 0x00000080. LH, addr 0x1002, rdata 0x12348001 -> 0xFFFF8001.
- LWL, addr 0x1001, rt_old 0xDEADBEEF, rdata 0x11223344 -> 0x223344EF. LWR at the same inputs -> 0xDEAD1122.
- SW, ack delayed 4 cycles -> o_bus_req/o_stall held 5 cycles with bus outputs stable, then o_stall=0 for one DONE cycle with no o_load_valid.
- SW with i_bad_addr=1 -> o_exc_ades=1 the same cycle, o_bus_req never asserted. i_rst during BUS -> o_bus_req=0 after that edge; a late ack is ignored.
- LLSC_EN defined: LL then SC -> SC bus write, result 1. i_llbit_clr between LL and SC -> SC result 0, no o_bus_req.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus bundle between the MEM-stage access unit and memory.
// Single outstanding req/ack transaction; rdata is valid alongside ack.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        sel;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata, sel,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, sel,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: bus transaction, stall, load align/extend.
// Optional LL/SC reservation bit enabled by defining LLSC_EN.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter bit WORD_ALIGN_BUS = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_flush,
    input  logic [5:0]  i_instr_op,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_sel,
    input  logic        i_bad_addr,
    input  logic [31:0] i_rt_old,
    input  logic        i_llbit_clr,
    mem_access_unit_if.master bus,
    output logic        o_stall,
    output logic        o_load_valid,
    output logic [31:0] o_load_data,
    output logic        o_exc_adel,
    output logic        o_exc_ades
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2a;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SWR = 6'h2e;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    logic [1:0]  state;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] rt_q;
    logic        we_q;
    logic        drop_q;
    logic        ld_in;
    logic        st_in;
    logic        go;
    logic        sc_skip;
    logic        lv_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] fmt_data;

    always_comb begin
        ld_in = 1'b0;
        st_in = 1'b0;
        case (i_instr_op)
            OP_LB, OP_LBU, OP_LH, OP_LHU,
            OP_LW, OP_LWL, OP_LWR, OP_LL: ld_in = 1'b1;
            OP_SB, OP_SH, OP_SW,
            OP_SWL, OP_SWR, OP_SC:        st_in = 1'b1;
            default: ;
        endcase
    end

    assign go = i_valid & (ld_in | st_in) & ~i_flush;

`ifdef LLSC_EN
    logic llbit_q;

    // A failing SC never reaches the bus; it stalls once and reports 0.
    assign sc_skip = (i_instr_op == OP_SC) & ~llbit_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            llbit_q <= 1'b0;
        else if (i_llbit_clr)
            llbit_q <= 1'b0;
        else if (state == BUS && bus.ack && op_q == OP_LL)
            llbit_q <= 1'b1;
        else if (state == BUS && bus.ack && op_q == OP_SC)
            llbit_q <= 1'b0;
    end
`else
    logic unused_llbit_clr;

    assign sc_skip          = 1'b0;
    assign unused_llbit_clr = i_llbit_clr;
`endif

    always_comb begin
        lane_b = bus.rdata[31:24];
        case (addr_q[1:0])
            2'd0: lane_b = bus.rdata[31:24];
            2'd1: lane_b = bus.rdata[23:16];
            2'd2: lane_b = bus.rdata[15:8];
            2'd3: lane_b = bus.rdata[7:0];
            default: ;
        endcase
        lane_h = addr_q[1] ? bus.rdata[15:0] : bus.rdata[31:16];
        fmt_data = bus.rdata;
        case (op_q)
            OP_LB:  fmt_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU: fmt_data = {24'h0, lane_b};
            OP_LH:  fmt_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU: fmt_data = {16'h0, lane_h};
            OP_LWL: begin
                case (addr_q[1:0])
                    2'd1: fmt_data = {bus.rdata[23:0], rt_q[7:0]};
                    2'd2: fmt_data = {bus.rdata[15:0], rt_q[15:0]};
                    2'd3: fmt_data = {bus.rdata[7:0], rt_q[23:0]};
                    default: fmt_data = bus.rdata;
                endcase
            end
            OP_LWR: begin
                case (addr_q[1:0])
                    2'd0: fmt_data = {rt_q[31:8], bus.rdata[31:24]};
                    2'd1: fmt_data = {rt_q[31:16], bus.rdata[31:16]};
                    2'd2: fmt_data = {rt_q[31:24], bus.rdata[31:8]};
                    default: fmt_data = bus.rdata;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            op_q        <= 6'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            sel_q       <= 4'h0;
            rt_q        <= 32'h0;
            we_q        <= 1'b0;
            drop_q      <= 1'b0;
            lv_q        <= 1'b0;
            o_load_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && !i_bad_addr) begin
                        op_q    <= i_instr_op;
                        addr_q  <= i_mem_addr;
                        wdata_q <= i_mem_wdata;
                        sel_q   <= i_mem_sel;
                        rt_q    <= i_rt_old;
                        we_q    <= st_in;
                        drop_q  <= 1'b0;
                        lv_q    <= ld_in | (i_instr_op == OP_SC);
                        if (sc_skip) begin
                            o_load_data <= 32'h0;
                            state       <= DONE;
                        end else begin
                            state <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (i_flush)
                        drop_q <= 1'b1;
                    if (bus.ack) begin
                        state <= DONE;
                        // Flushed results never reach the register file.
                        if (!drop_q && !i_flush) begin
                            if (op_q == OP_SC)
                                o_load_data <= 32'h1;
                            else if (!we_q)
                                o_load_data <= fmt_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req   = (state == BUS);
    assign bus.we    = we_q;
    assign bus.wdata = wdata_q;
    assign bus.sel   = sel_q;
    assign bus.addr  = WORD_ALIGN_BUS ? {addr_q[ADDR_W-1:2], 2'b00}
                                      : addr_q[ADDR_W-1:0];

    assign o_stall      = (state == BUS) |
                          (state == IDLE & go & ~i_bad_addr);
    assign o_load_valid = (state == DONE) & lv_q & ~drop_q;
    assign o_exc_adel   = (state == IDLE) & go & i_bad_addr & ld_in;
    assign o_exc_ades   = (state == IDLE) & go & i_bad_addr & st_in;
endmodule
